// File: rtl/lpc_quant_scheduler_if.sv
// Bundle of the enable, load, quantizer and result signals of lpc_quant_scheduler.
// slave  : scheduler side.
// master : surrounding logic (LPC solver, quantizer, frame writer).
// QSCHED_ORDER_CHECK_EN adds the oError strobe.
interface lpc_quant_scheduler_if;
    logic        iEnable;
    logic        iStart;
    logic [5:0]  iOrder;
    logic        iValid;
    logic [31:0] iFloatCoeff;
    logic        oReady;
    logic        oQValid;
    logic [31:0] oQFloatCoeff;
    logic        iQValid;
    logic [11:0] iQCoeff;
    logic        oCoeffValid;
    logic [11:0] oCoeff;
    logic [4:0]  oCoeffIndex;
    logic [4:0]  oShift;
    logic        oBusy;
    logic        oDone;
`ifdef QSCHED_ORDER_CHECK_EN
    logic        oError;

    modport slave (
        input  iEnable, iStart, iOrder, iValid, iFloatCoeff, iQValid, iQCoeff,
        output oReady, oQValid, oQFloatCoeff, oCoeffValid, oCoeff, oCoeffIndex,
               oShift, oBusy, oDone, oError
    );
    modport master (
        output iEnable, iStart, iOrder, iValid, iFloatCoeff, iQValid, iQCoeff,
        input  oReady, oQValid, oQFloatCoeff, oCoeffValid, oCoeff, oCoeffIndex,
               oShift, oBusy, oDone, oError
    );
`else
    modport slave (
        input  iEnable, iStart, iOrder, iValid, iFloatCoeff, iQValid, iQCoeff,
        output oReady, oQValid, oQFloatCoeff, oCoeffValid, oCoeff, oCoeffIndex,
               oShift, oBusy, oDone
    );
    modport master (
        output iEnable, iStart, iOrder, iValid, iFloatCoeff, iQValid, iQCoeff,
        input  oReady, oQValid, oQFloatCoeff, oCoeffValid, oCoeff, oCoeffIndex,
               oShift, oBusy, oDone
    );
`endif
endinterface

// File: rtl/lpc_quant_scheduler.sv
// LPC coefficient quantizer sequencer.
// Loads a set of IEEE-754 single coefficients, derives the qlp shift from the
// largest exponent, streams pre-scaled coefficients to the quantizer and
// forwards the quantizer results with an index to the frame writer.
// Option macro QSCHED_ORDER_CHECK_EN: reject out-of-range orders and pulse
// oError, instead of clamping them.
module lpc_quant_scheduler #(
    parameter int unsigned MAX_ORDER = 32,
    parameter int unsigned PRECISION = 12,
    parameter int unsigned MAX_SHIFT = 15
) (
    input logic                 iClock,
    input logic                 iReset,
    lpc_quant_scheduler_if.slave bus
);
    localparam int unsigned AW = $clog2(MAX_ORDER);
    localparam int unsigned CW = $clog2(MAX_ORDER + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_ISSUE,
        S_DRAIN
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   order_q, order_d;
    logic [CW-1:0]   wr_q, wr_d;
    logic [CW-1:0]   rd_q, rd_d;
    logic [CW-1:0]   rc_q, rc_d;
    logic [7:0]      maxexp_q, maxexp_d;
    logic [4:0]      shift_q, shift_d;
    logic            cvalid_q, cvalid_d;
    logic [11:0]     coeff_q, coeff_d;
    logic [4:0]      cidx_q, cidx_d;
    logic            err_q, err_d;
    logic            mem_we;
    logic [31:0]     coef_mem_q [MAX_ORDER];
    logic [10:0]     raw_shift;
    logic [4:0]      shift_calc;
    logic            order_ok;
    logic [CW-1:0]   order_clamped;
    logic [31:0]     mem_word;
    logic [7:0]      exp_sum;

    // Order range decode: clamped value and whether it was in range.
    always_comb begin
        order_ok = 1'b1;
        order_clamped = CW'(bus.iOrder);
        if (bus.iOrder == '0) begin
            order_ok = 1'b0;
            order_clamped = CW'(1);
        end else if (32'(bus.iOrder) > MAX_ORDER) begin
            order_ok = 1'b0;
            order_clamped = CW'(MAX_ORDER);
        end
    end

    // qlp shift: PRECISION+125-maxexp, clamped to [0,MAX_SHIFT]; all-zero set gives 0.
    always_comb begin
        raw_shift = 11'(PRECISION + 125) - 11'(maxexp_q);
        shift_calc = '0;
        if (maxexp_q == '0 || raw_shift[10]) begin
            shift_calc = '0;
        end else if (raw_shift > 11'(MAX_SHIFT)) begin
            shift_calc = 5'(MAX_SHIFT);
        end else begin
            shift_calc = raw_shift[4:0];
        end
    end

    // State and datapath registers; iEnable low freezes everything.
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state_q  <= S_IDLE;
            order_q  <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            rc_q     <= '0;
            maxexp_q <= '0;
            shift_q  <= '0;
            cvalid_q <= 1'b0;
            coeff_q  <= '0;
            cidx_q   <= '0;
            err_q    <= 1'b0;
        end else if (bus.iEnable) begin
            state_q  <= state_d;
            order_q  <= order_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            rc_q     <= rc_d;
            maxexp_q <= maxexp_d;
            shift_q  <= shift_d;
            cvalid_q <= cvalid_d;
            coeff_q  <= coeff_d;
            cidx_q   <= cidx_d;
            err_q    <= err_d;
        end
    end

    // Coefficient buffer, deliberately not reset.
    always_ff @(posedge iClock) begin
        if (bus.iEnable && mem_we) begin
            coef_mem_q[wr_q[AW-1:0]] <= bus.iFloatCoeff;
        end
    end

    // Next-state and counter logic (registers only advance when enabled).
    always_comb begin
        state_d  = state_q;
        order_d  = order_q;
        wr_d     = wr_q;
        rd_d     = rd_q;
        rc_d     = rc_q;
        maxexp_d = maxexp_q;
        shift_d  = shift_q;
        cvalid_d = 1'b0;
        coeff_d  = coeff_q;
        cidx_d   = cidx_q;
        err_d    = 1'b0;
        mem_we   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.iStart) begin
`ifdef QSCHED_ORDER_CHECK_EN
                    if (!order_ok) begin
                        err_d = 1'b1;
                    end else begin
                        order_d  = order_clamped;
                        wr_d     = '0;
                        rd_d     = '0;
                        rc_d     = '0;
                        maxexp_d = '0;
                        state_d  = S_LOAD;
                    end
`else
                    order_d  = order_clamped;
                    wr_d     = '0;
                    rd_d     = '0;
                    rc_d     = '0;
                    maxexp_d = '0;
                    state_d  = S_LOAD;
`endif
                end
            end
            S_LOAD: begin
                if (bus.iValid) begin
                    mem_we = 1'b1;
                    wr_d   = wr_q + CW'(1);
                    if (bus.iFloatCoeff[30:23] > maxexp_q) begin
                        maxexp_d = bus.iFloatCoeff[30:23];
                    end
                    if (wr_q == order_q - CW'(1)) begin
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                shift_d = shift_calc;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                rd_d = rd_q + CW'(1);
                if (rd_q == order_q - CW'(1)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (rc_q == order_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Results may already return while coefficients are still being issued.
        if ((state_q == S_ISSUE || state_q == S_DRAIN) && bus.iQValid && (rc_q < order_q)) begin
            cvalid_d = 1'b1;
            coeff_d  = bus.iQCoeff;
            cidx_d   = 5'(rc_q);
            rc_d     = rc_q + CW'(1);
        end
    end

    // Output decode from state, counters and the buffer.
    always_comb begin
        mem_word          = coef_mem_q[rd_q[AW-1:0]];
        exp_sum           = mem_word[30:23] + {3'b000, shift_q};
        bus.oReady        = (state_q == S_LOAD);
        bus.oBusy         = (state_q != S_IDLE);
        bus.oDone         = (state_q == S_DRAIN) && (rc_q == order_q);
        bus.oQValid       = 1'b0;
        bus.oQFloatCoeff  = '0;
        if (state_q == S_ISSUE) begin
            bus.oQValid = 1'b1;
            if (mem_word[30:23] == '0) begin
                bus.oQFloatCoeff = mem_word;
            end else begin
                bus.oQFloatCoeff = {mem_word[31], exp_sum, mem_word[22:0]};
            end
        end
    end

    assign bus.oCoeffValid = cvalid_q;
    assign bus.oCoeff      = coeff_q;
    assign bus.oCoeffIndex = cidx_q;
    assign bus.oShift      = shift_q;
`ifdef QSCHED_ORDER_CHECK_EN
    assign bus.oError      = err_q;
`else
    logic unused_err;
    assign unused_err = err_q ^ order_ok;
`endif
endmodule

// File: tb/tb_lpc_quant_scheduler.sv
// Scoreboard bench for lpc_quant_scheduler: stimulus pushes expected
// quantizer inputs, results and shifts; a negedge monitor pops and compares.
module tb_lpc_quant_scheduler;
    logic iClock = 1'b0;
    logic iReset = 1'b0;
    always #5 iClock = ~iClock;

    lpc_quant_scheduler_if bus ();

    lpc_quant_scheduler #(.MAX_ORDER(32), .PRECISION(12), .MAX_SHIFT(15)) dut (
        .iClock (iClock),
        .iReset (iReset),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    logic [31:0] qexp [$];     // expected oQFloatCoeff in order
    logic [11:0] qres [$];     // quantizer results to return, in order
    logic [16:0] cexp [$];     // expected {index, coeff}
    logic [4:0]  sexp [$];     // expected oShift at oDone
    logic [11:0] pending [$];  // quantizer results awaiting return
    logic        consumed = 1'b0;
    int          cyc = 0;

    logic [31:0] w  [32];
    logic [31:0] qf [32];
    logic [11:0] qr [32];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic put(input int i, input logic [31:0] wv, input logic [31:0] qv, input int rv);
        w[i]  = wv;
        qf[i] = qv;
        qr[i] = 12'(rv);
    endtask

    function automatic logic [58:0] outs();
        return {bus.oReady, bus.oQValid, bus.oQFloatCoeff, bus.oCoeffValid, bus.oCoeff,
                bus.oCoeffIndex, bus.oShift, bus.oBusy, bus.oDone};
    endfunction

    // Monitor: outputs presented on an enabled cycle are consumed at the next edge.
    always @(negedge iClock) begin
        if (iReset) begin
            if (bus.iEnable) begin
                if (bus.oQValid) begin
                    if (qexp.size() == 0) check("qfloat_extra", 1, 0);
                    else check("qfloat", bus.oQFloatCoeff, qexp.pop_front());
                    if (qres.size() == 0) check("qres_underflow", 1, 0);
                    else pending.push_back(qres.pop_front());
                end
                if (bus.oCoeffValid) begin
                    if (cexp.size() == 0) check("coeff_extra", 1, 0);
                    else begin
                        logic [16:0] e;
                        e = cexp.pop_front();
                        check("coeff_idx", bus.oCoeffIndex, e[16:12]);
                        check("coeff_val", bus.oCoeff, e[11:0]);
                    end
                end
                if (bus.oDone) begin
                    done_cnt++;
                    check("done_after_last", cexp.size(), 0);
                    if (sexp.size() == 0) check("done_extra", 1, 0);
                    else check("shift", bus.oShift, sexp.pop_front());
                end
                consumed = bus.iQValid;
            end else begin
                consumed = 1'b0;
                if (bus.oQValid && qexp.size() > 0) check("qfloat_hold", bus.oQFloatCoeff, qexp[0]);
            end
        end
    end

    // Quantizer model: returns results in order, skipping every third cycle.
    always @(posedge iClock) begin
        #1;
        cyc++;
        if (consumed) begin
            bus.iQValid = 1'b0;
            consumed = 1'b0;
        end
        if (!bus.iQValid && pending.size() > 0 && (cyc % 3) != 2) begin
            bus.iQCoeff = pending.pop_front();
            bus.iQValid = 1'b1;
        end
    end

    task automatic run_set(input int ord_in, input int n, input int shift, input bit abuse);
        int start;
        for (int i = 0; i < n; i++) begin
            qexp.push_back(qf[i]);
            qres.push_back(qr[i]);
            cexp.push_back({5'(i), qr[i]});
        end
        sexp.push_back(5'(shift));
        bus.iStart = 1'b1;
        bus.iOrder = 6'(ord_in);
        @(posedge iClock); #1;
        bus.iStart = 1'b0;
        check("load_ready_busy", {bus.oReady, bus.oBusy}, 2'b11);
        for (int i = 0; i < n; i++) begin
            if (i % 5 == 4) begin
                bus.iValid = 1'b0;
                @(posedge iClock); #1;
            end
            bus.iValid = 1'b1;
            bus.iFloatCoeff = w[i];
            @(posedge iClock); #1;
        end
        bus.iValid = 1'b0;
        bus.iFloatCoeff = 32'hdeadbeef;
        if (abuse) begin
            @(posedge iClock); #1;
            @(posedge iClock); #1;
            bus.iStart = 1'b1;
            bus.iOrder = 6'd3;
            @(posedge iClock); #1;
            bus.iStart = 1'b0;
            bus.iEnable = 1'b0;
            repeat (3) begin @(posedge iClock); #1; end
            bus.iEnable = 1'b1;
        end
        start = done_cnt;
        for (int c = 0; c < 400 && done_cnt == start; c++) begin
            @(posedge iClock); #1;
        end
        check("done_seen", done_cnt != start, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.iEnable = 1'b1;
        bus.iStart = 1'b0;
        bus.iOrder = '0;
        bus.iValid = 1'b0;
        bus.iFloatCoeff = '0;
        bus.iQValid = 1'b0;
        bus.iQCoeff = '0;
        #12;
        check("reset_outputs", outs(), 0);
        @(negedge iClock);
        iReset = 1'b1;
        @(posedge iClock); #1;

        // Order 13, max exponent 127 -> shift 10 (exponent +10 = +0x05000000).
        put(0,  32'h3f800000, 32'h44800000, 1024);
        put(1,  32'h3f7f7bb8, 32'h447f7bb8, 1022);
        put(2,  32'hbf7e0430, 32'hc47e0430, -1016);
        put(3,  32'h3f000000, 32'h44000000, 512);
        put(4,  32'hbe800000, 32'hc3800000, -256);
        put(5,  32'h3f400000, 32'h44400000, 768);
        put(6,  32'h3e000000, 32'h43000000, 128);
        put(7,  32'hbf000000, 32'hc4000000, -512);
        put(8,  32'h3ec00000, 32'h43c00000, 384);
        put(9,  32'hbe000000, 32'hc3000000, -128);
        put(10, 32'h3d800000, 32'h42800000, 64);
        put(11, 32'hbf400000, 32'hc4400000, -768);
        put(12, 32'h3f4401d3, 32'h444401d3, 784);
        run_set(13, 13, 10, 1'b1);

        // Reset in the middle of LOAD aborts with all outputs cleared.
        bus.iStart = 1'b1;
        bus.iOrder = 6'd4;
        @(posedge iClock); #1;
        bus.iStart = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.iValid = 1'b1;
            bus.iFloatCoeff = 32'h3f800000;
            @(posedge iClock); #1;
        end
        iReset = 1'b0;
        #1;
        bus.iValid = 1'b0;
        check("reset_midload", outs(), 0);
        @(negedge iClock);
        @(negedge iClock);
        iReset = 1'b1;
        @(posedge iClock); #1;

        // Order 4, all zero -> shift 0, words pass unchanged.
        for (int i = 0; i < 4; i++) put(i, 32'h0, 32'h0, 0);
        run_set(4, 4, 0, 1'b0);

        // Order 2, 0.001 -> raw shift 20 clamped to 15; exponent 117+15 = 132.
        put(0, 32'h3a83126f, 32'h4203126f, 33);
        put(1, 32'hba83126f, 32'hc203126f, -33);
        run_set(2, 2, 15, 1'b0);

        // Order 1, 8.0 -> shift 7; 8*2^7 = 1024.0.
        put(0, 32'h41000000, 32'h44800000, 1024);
        run_set(1, 1, 7, 1'b0);

        // iOrder 0 clamps to 1: -3.0 -> shift 9 -> -1536.0.
        put(0, 32'hc0400000, 32'hc4c00000, -1536);
        run_set(0, 1, 9, 1'b0);

        // iOrder 40 clamps to 32: +/-0.25 -> shift 12 -> +/-1024.0, tags = index.
        for (int i = 0; i < 32; i++) begin
            if (i % 2 == 0) put(i, 32'h3e800000, 32'h44800000, i);
            else            put(i, 32'hbe800000, 32'hc4800000, i);
        end
        run_set(40, 32, 12, 1'b0);

        repeat (5) begin @(posedge iClock); #1; end
        check("qexp_empty", qexp.size(), 0);
        check("cexp_empty", cexp.size(), 0);
        check("pending_empty", pending.size() + qres.size(), 0);
        check("done_count", done_cnt, 6);
        check("idle_at_end", {bus.oBusy, bus.oQValid, bus.oReady}, 3'b000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
